// File: rtl/ltc2333_read.sv
// LTC2333 receive path: synchronizes per-lane SCKO/SDO, deserializes 24-bit packets,
// arbitrates lane holding registers into an output FIFO presented as AXI-Stream.

module ltc2333_lane #(
  parameter int PACKET_BITS    = 24,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm_i,
  input  logic                   edge_i,
  input  logic                   sdo_i,
  input  logic [7:0]             mask_i,
  input  logic                   pop_i,
  output logic                   hold_full_o,
  output logic [PACKET_BITS-1:0] hold_data_o,
  output logic                   ovf_o,
  output logic                   tout_o,
  output logic                   cerr_o
);
  localparam int BW = $clog2(PACKET_BITS);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q;
  logic [BW-1:0]          bitcnt_q;
  logic [TW-1:0]          tcnt_q;
  logic [PACKET_BITS-1:0] shreg_q, pkt_d;
  logic                   act, complete, load, tmo;

  assign act      = (state_q == ACTIVE);
  assign pkt_d    = {shreg_q[PACKET_BITS-2:0], sdo_i};
  // An arm in the same cycle as an edge wins, so the edge is not shifted in.
  assign complete = act && !arm_i && edge_i && (bitcnt_q == BW'(PACKET_BITS-1));
  assign load     = complete && (!hold_full_o || pop_i);
  assign tmo      = act && !arm_i && !edge_i && (tcnt_q == TW'(TIMEOUT_CYCLES-1));

  assign ovf_o  = complete && hold_full_o && !pop_i;
  assign cerr_o = load && !mask_i[pkt_d[5:3]];
  assign tout_o = act && (bitcnt_q != '0) && (arm_i || tmo);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      tcnt_q      <= '0;
      shreg_q     <= '0;
      hold_full_o <= 1'b0;
      hold_data_o <= '0;
    end else begin
      if (pop_i) hold_full_o <= 1'b0;
      if (load) begin
        hold_full_o <= 1'b1;
        hold_data_o <= pkt_d;
      end
      case (state_q)
        IDLE: if (arm_i) begin
          state_q  <= ACTIVE;
          bitcnt_q <= '0;
          tcnt_q   <= '0;
        end
        ACTIVE: begin
          if (arm_i) begin
            bitcnt_q <= '0;
            tcnt_q   <= '0;
          end else if (edge_i) begin
            shreg_q  <= pkt_d;
            tcnt_q   <= '0;
            bitcnt_q <= complete ? '0 : bitcnt_q + 1'b1;
          end else if (tmo) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            tcnt_q   <= '0;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

module ltc2333_read #(
  parameter int N_ADC          = 2,
  parameter int PACKET_BITS    = 24,
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnv,
  input  logic [N_ADC-1:0] scko,
  input  logic [N_ADC-1:0] sdo,
  input  logic [7:0]       expected_channels,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             overflow,
  output logic             chan_err,
  output logic             timeout_err,
  input  logic             err_clear
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0][N_ADC-1:0] scko_sync_q, sdo_sync_q;
  logic [N_ADC-1:0] scko_prev_q, scko_rise, sdo_s;
  logic             cnv_q, cnv_prev_q, arm;

  always_ff @(posedge clk) begin
    if (reset) begin
      scko_sync_q <= '0;
      sdo_sync_q  <= '0;
      scko_prev_q <= '0;
      cnv_q       <= 1'b0;
      cnv_prev_q  <= 1'b0;
    end else begin
      scko_sync_q <= {scko_sync_q[SYNC_STAGES-2:0], scko};
      sdo_sync_q  <= {sdo_sync_q[SYNC_STAGES-2:0], sdo};
      scko_prev_q <= scko_sync_q[SYNC_STAGES-1];
      cnv_q       <= cnv;
      cnv_prev_q  <= cnv_q;
    end
  end

  assign scko_rise = scko_sync_q[SYNC_STAGES-1] & ~scko_prev_q;
  assign sdo_s     = sdo_sync_q[SYNC_STAGES-1];
  assign arm       = cnv_q & ~cnv_prev_q;

  logic [N_ADC-1:0]                  hold_full, lane_pop, ovf_p, tout_p, cerr_p;
  logic [N_ADC-1:0][PACKET_BITS-1:0] hold_data;

  for (genvar g = 0; g < N_ADC; g++) begin : g_lane
    ltc2333_lane #(.PACKET_BITS(PACKET_BITS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_lane (
      .clk         (clk),
      .reset       (reset),
      .arm_i       (arm),
      .edge_i      (scko_rise[g]),
      .sdo_i       (sdo_s[g]),
      .mask_i      (expected_channels),
      .pop_i       (lane_pop[g]),
      .hold_full_o (hold_full[g]),
      .hold_data_o (hold_data[g]),
      .ovf_o       (ovf_p[g]),
      .tout_o      (tout_p[g]),
      .cerr_o      (cerr_p[g])
    );
  end

  logic [2:0]             sel, top_ch;
  logic                   any_full, fifo_we, fifo_pop, fifo_full;
  logic [PACKET_BITS-1:0] sel_data;
  logic [32:0]            wr_word;

  // Descending scan so the lowest-index full lane is the last assignment.
  always_comb begin
    sel      = '0;
    sel_data = '0;
    any_full = 1'b0;
    for (int i = N_ADC - 1; i >= 0; i--) begin
      if (hold_full[i]) begin
        sel      = 3'(i);
        sel_data = hold_data[i];
        any_full = 1'b1;
      end
    end
    top_ch = '0;
    for (int c = 0; c < 8; c++) if (expected_channels[c]) top_ch = 3'(c);
  end

  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  assign fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_pop  = m_axis_tvalid && m_axis_tready;
  assign fifo_we   = any_full && (!fifo_full || fifo_pop);
  assign wr_word   = {(expected_channels != 8'd0) && (sel_data[5:3] == top_ch),
                      sel, sel_data[5:3], sel_data[2:0], 5'b0, sel_data[23:6]};

  always_comb begin
    lane_pop = '0;
    for (int i = 0; i < N_ADC; i++) lane_pop[i] = fifo_we && (sel == 3'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_we)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_we, fifo_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_we) mem_q[wr_ptr_q] <= wr_word;
  end

  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q][31:0] : 32'd0;
  assign m_axis_tlast  = m_axis_tvalid && mem_q[rd_ptr_q][32];

  // A set in the same cycle as err_clear keeps the flag high.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow    <= 1'b0;
      chan_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      overflow    <= (|ovf_p)  ? 1'b1 : (err_clear ? 1'b0 : overflow);
      chan_err    <= (|cerr_p) ? 1'b1 : (err_clear ? 1'b0 : chan_err);
      timeout_err <= (|tout_p) ? 1'b1 : (err_clear ? 1'b0 : timeout_err);
    end
  end
endmodule

// File: tb/tb_ltc2333_read.sv
// Scoreboarded bench for ltc2333_read: stimulus pushes expected words, a monitor pops on handshake.

module tb_ltc2333_read;
  localparam int N = 2;

  logic          clk = 1'b0, reset = 1'b1, cnv = 1'b0, err_clear = 1'b0;
  logic [N-1:0]  scko = '0, sdo = '0;
  logic [7:0]    mask = 8'h00;
  logic [31:0]   tdata;
  logic          tvalid, tlast, tready, ovf, cerr, terr;
  logic          tready_man = 1'b1, rnd_en = 1'b0, rnd_bit = 1'b1;

  int            n_chk = 0, n_fail = 0;
  logic [32:0]   exp_q[$];
  logic          m_cerr = 1'b0;

  assign tready = rnd_en ? rnd_bit : tready_man;

  ltc2333_read #(.N_ADC(N), .PACKET_BITS(24), .FIFO_DEPTH(8), .SYNC_STAGES(2),
                 .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .cnv(cnv), .scko(scko), .sdo(sdo),
    .expected_channels(mask), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .overflow(ovf),
    .chan_err(cerr), .timeout_err(terr), .err_clear(err_clear));

  always #5 clk = ~clk;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word is compared with the head of the scoreboard.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected none", tdata);
      end else begin
        e = exp_q.pop_front();
        check("axis_word", {31'b0, tlast, tdata}, {31'b0, e});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm();
    cnv = 1'b1; tick(3);
    cnv = 1'b0; tick(3);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1; tick(1);
    err_clear = 1'b0; tick(1);
  endtask

  function automatic logic [23:0] mk(input logic [17:0] r, input logic [2:0] ch, input logic [2:0] sp);
    return {r, ch, sp};
  endfunction

  // Reference: word layout and tlast/chan_err rules derived from the channel mask.
  task automatic push(input int idx, input logic [23:0] p);
    int hi;
    logic tl;
    hi = -1;
    for (int c = 0; c < 8; c++) if (mask[c]) hi = c;
    tl = (hi >= 0) && (int'(p[5:3]) == hi);
    if (!mask[p[5:3]]) m_cerr = 1'b1;
    exp_q.push_back({tl, 3'(idx), p[5:3], p[2:0], 5'b0, p[23:6]});
  endtask

  task automatic send(input logic [N-1:0] en, input logic [N-1:0][23:0] pk, input int nb);
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < N; i++) if (en[i]) sdo[i] = pk[i][23-b];
      tick(3);
      scko = en; tick(3);
      scko = '0;
    end
  endtask

  task automatic wait_drain(input string name, input int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || tvalid) && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    tick(1);
  endtask

  function automatic logic [23:0] rnd_pkt(input logic [2:0] ch);
    return mk(18'($urandom), ch, 3'($urandom));
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] p, q;
    logic [N-1:0] en;
    int npk, k;

    tick(3);
    @(negedge clk);
    check("rst_tvalid", 64'(tvalid), 0);
    check("rst_tdata", 64'(tdata), 0);
    check("rst_tlast", 64'(tlast), 0);
    check("rst_ovf", 64'(ovf), 0);
    check("rst_cerr", 64'(cerr), 0);
    check("rst_terr", 64'(terr), 0);
    tick(1);
    reset = 1'b0;
    tick(2);

    // Single packet, tlast on highest mask channel.
    mask = 8'h04;
    arm();
    p = mk(18'h2AF37, 3'd2, 3'd5);
    push(0, p);
    send(2'b01, {24'h0, p}, 24);
    wait_drain("t1_drain", 60);
    check("t1_cerr", 64'(cerr), 64'(m_cerr));

    // Both lanes complete together: adc0 then adc1 on consecutive cycles.
    mask = 8'h06;
    tready_man = 1'b0;
    arm();
    p = mk(18'h15555, 3'd1, 3'd3);
    q = mk(18'h0AAAA, 3'd2, 3'd6);
    push(0, p); push(1, q);
    send(2'b11, {q, p}, 24);
    tick(8);
    check("t2_tvalid", 64'(tvalid), 1);
    check("t2_first_idx", 64'(tdata[31:29]), 0);
    tready_man = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t2_second_valid", 64'(tvalid), 1);
    check("t2_second_idx", 64'(tdata[31:29]), 1);
    wait_drain("t2_drain", 40);

    // FIFO full: 8 in FIFO, 9th held, 10th dropped.
    mask = 8'h01;
    tready_man = 1'b0;
    arm();
    for (int i = 0; i < 10; i++) begin
      p = rnd_pkt(3'd0);
      if (i < 9) push(0, p);
      send(2'b01, {24'h0, p}, 24);
    end
    tick(6);
    check("t3_ovf", 64'(ovf), 1);
    check("t3_hold_word", 64'({tlast, tdata}), 64'(exp_q[0]));
    tready_man = 1'b1;
    wait_drain("t3_drain", 100);
    check("t3_ovf_sticky", 64'(ovf), 1);
    pulse_clear();
    @(negedge clk);
    check("t3_ovf_clear", 64'(ovf), 0);
    tick(80);

    // Partial packet abandoned by timeout, then lane ignores edges while idle.
    arm();
    send(2'b01, {24'h0, rnd_pkt(3'd0)}, 10);
    tick(80);
    check("t4_terr", 64'(terr), 1);
    check("t4_no_word", 64'(tvalid), 0);
    pulse_clear();
    @(negedge clk);
    check("t4_terr_clear", 64'(terr), 0);
    tick(1);
    send(2'b01, {24'h0, rnd_pkt(3'd0)}, 24);
    tick(20);
    check("t4_idle_no_word", 64'(tvalid), 0);

    // Channel outside the mask: forwarded, chan_err set, no tlast.
    mask = 8'h0F;
    arm();
    p = mk(18'h3FFFF, 3'd6, 3'd1);
    push(0, p);
    send(2'b01, {24'h0, p}, 24);
    wait_drain("t5_drain", 60);
    check("t5_cerr", 64'(cerr), 64'(m_cerr));
    pulse_clear();
    m_cerr = 1'b0;
    @(negedge clk);
    check("t5_cerr_clear", 64'(cerr), 0);
    tick(1);

    // Reset mid-packet discards the partial packet silently.
    mask = 8'h04;
    arm();
    send(2'b01, {24'h0, rnd_pkt(3'd2)}, 12);
    reset = 1'b1; tick(2);
    reset = 1'b0; tick(2);
    arm();
    p = rnd_pkt(3'd2);
    push(0, p);
    send(2'b01, {24'h0, p}, 24);
    wait_drain("t6_drain", 60);
    check("t6_ovf", 64'(ovf), 0);
    check("t6_cerr", 64'(cerr), 0);
    check("t6_terr", 64'(terr), 0);

    // Randomized frames with random backpressure.
    rnd_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      mask = 8'($urandom_range(1, 255));
      en   = N'($urandom_range(1, 3));
      npk  = $urandom_range(1, 2);
      arm();
      for (k = 0; k < npk; k++) begin
        p = rnd_pkt(3'($urandom));
        q = rnd_pkt(3'($urandom));
        if (en[0]) push(0, p);
        if (en[1]) push(1, q);
        send(en, {q, p}, 24);
      end
      wait_drain("rnd_drain", 400);
      check("rnd_cerr", 64'(cerr), 64'(m_cerr));
      pulse_clear();
      m_cerr = 1'b0;
    end
    rnd_en = 1'b0;
    tick(2);
    check("rnd_ovf", 64'(ovf), 0);
    check("rnd_terr", 64'(terr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
